dfr_axi_lite_slave: RTL and testbench
=====================================

DFR_AXI_LITE_SLAVE -- requirements
Module: dfr_axi_lite_slave

Interface
REQ-001 Parameters SHALL be: C_S_AXI_DATA_WIDTH, 32, data width; C_S_AXI_ADDR_WIDTH, 30, byte address width; MEM_ADDR_WIDTH, 17, word address width of each memory region.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 S_AXI_ACLK  in  1  clock; all logic on rising edge.
REQ-004 S_AXI_ARESET  in  1  asynchronous active-high reset.
REQ-005 S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY  AXI4-Lite write channels, standard directions and widths.
REQ-006 S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels, standard directions and widths.
REQ-007 busy  in  1  DFR core busy.
REQ-008 debug_in  in  32  value returned for DEBUG register reads.
REQ-009 ctrl_reg, num_init_samples, num_train_samples, num_test_samples, num_steps_per_sample, num_init_steps, num_train_steps, num_test_steps  out  32 each  config register contents.
REQ-010 mem_sel  out  3  region: 1 input, 2 reservoir, 3 weight, 4 output, 0 none.
REQ-011 mem_addr  out  MEM_ADDR_WIDTH  word address, equal to AXI addr[MEM_ADDR_WIDTH+1:2].
REQ-012 mem_wen, mem_ren  out  1  single-cycle write and read strobes; mem_wdata  out  32; mem_rdata  in  32, valid exactly one cycle after mem_ren.

Function
REQ-013 Decode SHALL use addr[29:24]: 0x00 config, 0x01 input, 0x02 reservoir, 0x03 weight, 0x04 output; any other value is unmapped.
REQ-014 Config offsets (addr[7:0]) SHALL be CTRL 0x00, DEBUG 0x04 (read-only), then the seven num_* registers at 0x08 through 0x20 in the order listed in REQ-009; any other config offset is unmapped.
REQ-015 The FSM SHALL have states IDLE, WR_ACK, WR_RESP, RD_ADDR, RD_DATA.
REQ-016 IDLE with AWVALID and WVALID both high SHALL go to WR_ACK; AWREADY and WREADY SHALL be high for exactly that one cycle; the register or memory write (mem_wen pulse) SHALL occur in the same cycle.
REQ-017 WR_RESP SHALL hold BVALID high until BREADY; the FSM SHALL return to IDLE on the cycle the handshake completes.
REQ-018 IDLE with ARVALID (and no complete write pair) SHALL go to RD_ADDR; ARREADY SHALL be high for one cycle, the address SHALL be latched, and mem_ren SHALL pulse for memory regions.
REQ-019 RD_DATA SHALL load RDATA from mem_rdata (memory regions) or from the register/debug_in (config), and hold RVALID until RREADY.
REQ-020 A write pair and ARVALID seen together in IDLE SHALL be arbitrated as write first; the read SHALL be served after BVALID completes.
REQ-021 AWVALID without WVALID, or the reverse, SHALL NOT be accepted; the block SHALL wait in IDLE.
REQ-022 WSTRB SHALL be ignored; all writes are full 32-bit words.
REQ-023 Unmapped accesses SHALL return SLVERR (2'b10), with no strobe, no register change, and RDATA = 0; all mapped accesses SHALL return OKAY (2'b00).
REQ-024 Writes to num_* registers while busy=1 SHALL be dropped and return SLVERR; CTRL and memory writes SHALL always be performed.
REQ-025 A write to DEBUG SHALL be dropped and return OKAY.
REQ-026 Best-case latency: write, 2 cycles from AW/W valid to BVALID; read, 2 cycles from ARVALID to RVALID.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE; all READY/VALID outputs, strobes, mem_sel, mem_addr, mem_wdata, RDATA, RRESP, BRESP and all config registers SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately, with no response issued after release.

Structure
REQ-029 Region codes, config offsets, FSM state enum and response codes SHALL live in a shared package dfr_axi_pkg.
REQ-030 The design SHALL be one module with no sub-modules; config registers SHALL be a flat register file inside it.

Verification
REQ-031 Write 0x0014=100 -> num_steps_per_sample=100; BVALID 2 cycles after valid; BRESP=00.
REQ-032 Write 0x0100_0008=0xFFFFFF9C -> mem_sel=1, mem_addr=2, one-cycle mem_wen, mem_wdata=0xFFFFFF9C.
REQ-033 Read 0x0400_0004 with mem_rdata=0x0000_0012 -> mem_ren pulse, mem_addr=1, RDATA=0x12, RRESP=00, RVALID held until RREADY.
REQ-034 Write then read 0x0500_0000, and write 0x0000_0030 -> SLVERR on each, no strobes, RDATA=0.
REQ-035 AW/W and AR asserted in the same cycle -> write completes (BVALID) before ARREADY rises; with busy=1, a write to 0x0008 returns SLVERR and leaves the value unchanged.
REQ-036 Reset asserted while in RD_DATA -> RVALID=0 next edge, FSM in IDLE; a subsequent read of 0x0000 returns 0.

Source files
------------

// File: rtl/dfr_axi_pkg.sv
// Shared decode constants, response codes and FSM states
// for the DFR AXI4-Lite register/memory slave.
package dfr_axi_pkg;

  localparam logic [5:0] RGN_CFG = 6'h00;
  localparam logic [5:0] RGN_IN  = 6'h01;
  localparam logic [5:0] RGN_RES = 6'h02;
  localparam logic [5:0] RGN_WGT = 6'h03;
  localparam logic [5:0] RGN_OUT = 6'h04;

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_DEBUG = 8'h04;
  localparam logic [7:0] OFF_LAST  = 8'h20;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

  function automatic logic cfg_hit(input logic [7:0] off);
    return (off[1:0] == 2'b00) && (off <= OFF_LAST);
  endfunction

endpackage

// File: rtl/dfr_axi_lite_slave.sv
// AXI4-Lite slave: config register file plus four word-addressed
// memory regions reached through single-cycle strobes.
module dfr_axi_lite_slave
  import dfr_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 30,
  parameter int MEM_ADDR_WIDTH     = 17
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            busy,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   debug_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_init_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_train_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_test_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_steps_per_sample,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_init_steps,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_train_steps,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_test_steps,
  output logic [2:0]                      mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
  output logic                            mem_wen,
  output logic                            mem_ren,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  state_e state, nxt;

  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [1:0]    bresp_q, rresp_q;
  logic          rd_first;
  logic [DW-1:0] regs [0:8];

  logic [5:0]    region;
  logic [7:0]    off;
  logic [3:0]    idx;
  logic          is_mem, is_cfg, is_dbg, is_ctrl;
  logic          num_blocked, cfg_wen;
  logic [1:0]    wr_resp, rd_resp;
  logic [DW-1:0] rd_live;

  // Decode always works from the latched address
  assign region  = addr_q[29:24];
  assign off     = addr_q[7:0];
  assign idx     = off[5:2];
  assign is_mem  = (region >= RGN_IN) && (region <= RGN_OUT);
  assign is_cfg  = (region == RGN_CFG) && cfg_hit(off);
  assign is_dbg  = is_cfg && (off == OFF_DEBUG);
  assign is_ctrl = is_cfg && (off == OFF_CTRL);

  assign num_blocked = is_cfg && !is_ctrl && !is_dbg && busy;
  assign cfg_wen     = (state == WR_ACK) && is_cfg && !is_dbg
                       && !num_blocked;
  assign wr_resp = (is_mem || (is_cfg && !num_blocked))
                   ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = (is_mem || is_cfg) ? RESP_OKAY : RESP_SLVERR;
  assign rd_live = is_mem ? mem_rdata :
                   is_dbg ? debug_in  :
                   is_cfg ? regs[idx] : '0;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) nxt = WR_ACK;
        else if (S_AXI_ARVALID)            nxt = RD_ADDR;
      end
      WR_ACK:  nxt = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) nxt = IDLE;
      RD_ADDR: nxt = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (state == WR_ACK);
    S_AXI_WREADY  = (state == WR_ACK);
    S_AXI_BVALID  = (state == WR_RESP);
    S_AXI_ARREADY = (state == RD_ADDR);
    S_AXI_RVALID  = (state == RD_DATA);
    mem_wen       = (state == WR_ACK) && is_mem;
    mem_ren       = (state == RD_ADDR) && is_mem;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rd_first <= 1'b0;
      for (int i = 0; i < 9; i++) regs[i] <= '0;
    end else begin
      rd_first <= (state == RD_ADDR);
      if (state == IDLE && nxt == WR_ACK) begin
        addr_q  <= S_AXI_AWADDR;
        wdata_q <= S_AXI_WDATA;
      end else if (state == IDLE && nxt == RD_ADDR) begin
        addr_q <= S_AXI_ARADDR;
      end
      if (state == WR_ACK) bresp_q <= wr_resp;
      if (cfg_wen) regs[idx] <= wdata_q;
      if (state == RD_ADDR) rresp_q <= rd_resp;
      if (state == RD_DATA && rd_first) rdata_q <= rd_live;
    end
  end

  // Memory data arrives in the first RD_DATA cycle, held afterwards
  assign S_AXI_RDATA = (state != RD_DATA) ? '0 :
                       rd_first ? rd_live : rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_BRESP = bresp_q;

  assign mem_sel   = is_mem ? region[2:0] : 3'd0;
  assign mem_addr  = addr_q[MEM_ADDR_WIDTH+1:2];
  assign mem_wdata = wdata_q;

  assign ctrl_reg             = regs[0];
  assign num_init_samples     = regs[2];
  assign num_train_samples    = regs[3];
  assign num_test_samples     = regs[4];
  assign num_steps_per_sample = regs[5];
  assign num_init_steps       = regs[6];
  assign num_train_steps      = regs[7];
  assign num_test_steps       = regs[8];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_WSTRB, addr_q, regs[1]};

endmodule

// File: tb/tb_dfr_axi_lite_slave.sv
// Directed self-checking bench for dfr_axi_lite_slave.
// Expected values are hand-computed from the register/memory map.
module tb_dfr_axi_lite_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] debug_in;
  logic [31:0] ctrl_reg, n_isamp, n_trsamp, n_tesamp, n_sps;
  logic [31:0] n_isteps, n_trsteps, n_testeps;
  logic [2:0]  mem_sel;
  logic [16:0] mem_addr;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_wdata, mem_rdata, mem_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dfr_axi_lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy), .debug_in(debug_in),
    .ctrl_reg(ctrl_reg),
    .num_init_samples(n_isamp),
    .num_train_samples(n_trsamp),
    .num_test_samples(n_tesamp),
    .num_steps_per_sample(n_sps),
    .num_init_steps(n_isteps),
    .num_train_steps(n_trsteps),
    .num_test_steps(n_testeps),
    .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: data valid exactly one cycle after mem_ren
  always @(posedge clk)
    mem_rdata <= mem_ren ? mem_val : 32'hDEAD_BEEF;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [29:0] a, input logic [31:0] d,
                        input int hold, output logic [1:0] resp,
                        output int lat, output int wens,
                        output logic [2:0] sel,
                        output logic [16:0] maddr,
                        output logic [31:0] wd);
    bit aw_done = 1'b0;
    awaddr = a; wdata = d; wstrb = 4'h1;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    lat = -1; wens = 0; sel = '0; maddr = '0; wd = '0;
    resp = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (aw_done) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (mem_wen) begin
        wens++; sel = mem_sel; maddr = mem_addr; wd = mem_wdata;
      end
      if (awready && wready) aw_done = 1'b1;
      if (bvalid) begin lat = i; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    repeat (hold) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic axi_rd(input logic [29:0] a, input logic [31:0] mv,
                        input int hold, output logic [31:0] data,
                        output logic [1:0] resp, output int lat,
                        output int rens, output logic [16:0] maddr);
    bit ar_done = 1'b0;
    araddr = a; mem_val = mv; arvalid = 1'b1; rready = 1'b0;
    lat = -1; rens = 0; maddr = '0; data = 'x; resp = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ar_done) arvalid = 1'b0;
      if (mem_ren) begin rens++; maddr = mem_addr; end
      if (arready) ar_done = 1'b1;
      if (rvalid) begin lat = i; break; end
    end
    arvalid = 1'b0;
    data = rdata; resp = rresp;
    repeat (hold) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, data);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [2:0]  sel;
    logic [16:0] maddr;
    logic [31:0] wd, data;
    int lat, cnt, b_cyc, ar_cyc;
    bit aw_done, ar_done;

    rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    busy = 0; debug_in = 32'h1234_5678; mem_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_strobes", {mem_wen, mem_ren}, 2'b00);
    check("rst_ctrl", ctrl_reg, 32'h0);
    check("rst_mem_sel", mem_sel, 3'd0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Config write, 2-cycle latency, BVALID held
    axi_wr(30'h0000_0014, 32'd100, 2, resp, lat, cnt, sel, maddr, wd);
    check("sps_lat", lat, 2);
    check("sps_resp", resp, 2'b00);
    check("sps_val", n_sps, 32'd100);
    check("sps_no_wen", cnt, 0);

    // Input-memory write
    axi_wr(30'h0100_0008, 32'hFFFF_FF9C, 0, resp, lat, cnt, sel, maddr, wd);
    check("in_wr_resp", resp, 2'b00);
    check("in_wr_wen", cnt, 1);
    check("in_wr_sel", sel, 3'd1);
    check("in_wr_addr", maddr, 17'd2);
    check("in_wr_data", wd, 32'hFFFF_FF9C);

    // Output-memory read with RVALID hold
    axi_rd(30'h0400_0004, 32'h12, 2, data, resp, lat, cnt, maddr);
    check("out_rd_lat", lat, 2);
    check("out_rd_ren", cnt, 1);
    check("out_rd_addr", maddr, 17'd1);
    check("out_rd_data", data, 32'h12);
    check("out_rd_resp", resp, 2'b00);

    // Unmapped region and offset
    axi_wr(30'h0500_0000, 32'hAAAA_5555, 0, resp, lat, cnt, sel, maddr, wd);
    check("unm_wr_resp", resp, 2'b10);
    check("unm_wr_wen", cnt, 0);
    axi_rd(30'h0500_0000, 32'h77, 0, data, resp, lat, cnt, maddr);
    check("unm_rd_resp", resp, 2'b10);
    check("unm_rd_ren", cnt, 0);
    check("unm_rd_data", data, 32'h0);
    axi_wr(30'h0000_0030, 32'h55, 0, resp, lat, cnt, sel, maddr, wd);
    check("unm_off_resp", resp, 2'b10);
    check("unm_off_sps", n_sps, 32'd100);

    // busy gating: num_* dropped, CTRL still written
    axi_wr(30'h0000_0008, 32'd7, 0, resp, lat, cnt, sel, maddr, wd);
    check("isamp_val", n_isamp, 32'd7);
    busy = 1'b1;
    axi_wr(30'h0000_0008, 32'd5, 0, resp, lat, cnt, sel, maddr, wd);
    check("busy_resp", resp, 2'b10);
    check("busy_isamp", n_isamp, 32'd7);
    axi_wr(30'h0000_0000, 32'hA5, 0, resp, lat, cnt, sel, maddr, wd);
    check("busy_ctrl_resp", resp, 2'b00);
    check("busy_ctrl_val", ctrl_reg, 32'hA5);
    axi_wr(30'h0000_0004, 32'hFFFF_FFFF, 0, resp, lat, cnt, sel, maddr, wd);
    check("dbg_wr_resp", resp, 2'b00);
    busy = 1'b0;
    axi_wr(30'h0000_0020, 32'h0BAD_F00D, 0, resp, lat, cnt, sel, maddr, wd);
    check("tsteps_val", n_testeps, 32'h0BAD_F00D);
    axi_rd(30'h0000_0004, 32'h0, 0, data, resp, lat, cnt, maddr);
    check("dbg_rd_data", data, 32'h1234_5678);
    check("dbg_rd_resp", resp, 2'b00);
    axi_rd(30'h0000_0014, 32'h0, 0, data, resp, lat, cnt, maddr);
    check("sps_rd_data", data, 32'd100);

    // Simultaneous write pair and read: write wins
    awaddr = 30'h0000_001C; wdata = 32'h33; araddr = 30'h0000_001C;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    b_cyc = -1; ar_cyc = -1; aw_done = 0; ar_done = 0; data = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (aw_done) begin awvalid = 0; wvalid = 0; end
      if (ar_done) arvalid = 0;
      if (awready) aw_done = 1;
      if (bvalid && b_cyc < 0) b_cyc = i;
      if (arready && ar_cyc < 0) begin ar_cyc = i; ar_done = 1; end
      if (rvalid) begin data = rdata; break; end
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    check("arb_b_cyc", b_cyc, 2);
    check("arb_ar_cyc", ar_cyc, 4);
    check("arb_rdata", data, 32'h33);
    check("arb_rvalid_drop", rvalid, 1'b0);

    // Reset while in RD_DATA
    araddr = 30'h0400_0000; mem_val = 32'h99; arvalid = 1; rready = 0;
    ar_done = 0; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ar_done) arvalid = 0;
      if (arready) ar_done = 1;
      if (rvalid) begin cnt = 1; break; end
    end
    arvalid = 0;
    check("abort_in_rd_data", cnt, 1);
    rst = 1'b1;
    #1;
    check("abort_rvalid_now", rvalid, 1'b0);
    @(posedge clk); #1;
    check("abort_rvalid_edge", rvalid, 1'b0);
    check("abort_ctrl", ctrl_reg, 32'h0);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_resp", {rvalid, bvalid}, 2'b00);
    end
    axi_rd(30'h0000_0000, 32'h0, 0, data, resp, lat, cnt, maddr);
    check("post_rst_ctrl_rd", data, 32'h0);
    check("post_rst_lat", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
